// File: rtl/izh_array.sv
// Time-multiplexed Izhikevich neuron array: one shared update datapath sweeps N_CH channels per step.
// Optional per-channel saturating spike counters when SPIKE_CNT_EN is defined.
//   state | meaning
//   IDLE  | waiting for step
//   RUN   | updating channel ch, one per cycle
//   FIN   | done pulse, back to IDLE
module izh_array #(
  parameter int N_CH     = 4,
  parameter int W        = 16,
  parameter int FRAC     = 8,
  parameter int DT_SHIFT = 1,
  localparam int CW      = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            step,
  input  logic [CW-1:0]   cfg_ch,
  input  logic            cur_we,
  input  logic [7:0]      cur_data,
  input  logic            mode_we,
  input  logic [1:0]      mode_data,
  output logic            busy,
  output logic            done,
  output logic [N_CH-1:0] spike,
  output logic            overrun,
  input  logic [CW-1:0]   mon_ch,
  output logic [7:0]      mon_v,
  output logic [7:0]      mon_cnt
);

  localparam int W2 = 2 * W;
  localparam logic signed [W2-1:0] SMAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [W2-1:0] SMIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [W-1:0]  V_RST = W'(-65 * (2 ** FRAC));
  localparam logic signed [W-1:0]  U_RST = W'(-13 * (2 ** FRAC));

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t              state;
  logic [CW-1:0]       ch;
  logic signed [W-1:0] v_q    [N_CH];
  logic signed [W-1:0] u_q    [N_CH];
  logic [7:0]          cur_q  [N_CH];
  logic [1:0]          mode_q [N_CH];

  function automatic logic signed [W-1:0] sat(input logic signed [W2-1:0] x);
    if (x > SMAX) return SMAX[W-1:0];
    if (x < SMIN) return SMIN[W-1:0];
    return x[W-1:0];
  endfunction

  logic signed [W2-1:0] v_x, u_x, i_x, vsq, dv, v_n, u_n, bv, c_x, d_x, u_sp;
  logic [2:0]           a_sh;
  logic signed [W-1:0]  v_s, u_s, v_wr, u_wr;
  logic                 fire;

  // Datapath for the channel currently addressed by ch; all math at 2W bits.
  always_comb begin
    v_x = W2'(v_q[ch]);
    u_x = W2'(u_q[ch]);
    i_x = W2'(cur_q[ch]) <<< FRAC;
    a_sh = 3'd6;
    c_x  = W2'(-65);
    d_x  = W2'(8);
    case (mode_q[ch])
      2'd1: begin a_sh = 3'd6; c_x = W2'(-55); d_x = W2'(4); end
      2'd2: begin a_sh = 3'd6; c_x = W2'(-50); d_x = W2'(2); end
      2'd3: begin a_sh = 3'd3; c_x = W2'(-65); d_x = W2'(2); end
      default: ;
    endcase
    vsq  = (v_x * v_x) >>> FRAC;
    dv   = (vsq >>> 5) + (vsq >>> 7) + (v_x <<< 2) + v_x + (W2'(140) <<< FRAC) - u_x + i_x;
    v_n  = v_x + (dv >>> DT_SHIFT);
    bv   = (v_x >>> 3) + (v_x >>> 4) + (v_x >>> 6);
    u_n  = u_x + (((bv - u_x) >>> a_sh) >>> DT_SHIFT);
    v_s  = sat(v_n);
    u_s  = sat(u_n);
    fire = W2'(v_s) >= (W2'(30) <<< FRAC);
    u_sp = W2'(u_s) + (d_x <<< FRAC);
    v_wr = fire ? W'(c_x <<< FRAC) : v_s;
    u_wr = fire ? sat(u_sp) : u_s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ch      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
      spike   <= '0;
      mon_v   <= 8'hBF;
      for (int i = 0; i < N_CH; i++) begin
        v_q[i]    <= V_RST;
        u_q[i]    <= U_RST;
        cur_q[i]  <= 8'd0;
        mode_q[i] <= 2'd0;
      end
    end else begin
      done  <= 1'b0;
      mon_v <= v_q[mon_ch][FRAC+7:FRAC];
      // Config writes land via NBA, so an update in the same cycle still sees the old value.
      if (cur_we)  cur_q[cfg_ch]  <= cur_data;
      if (mode_we) mode_q[cfg_ch] <= mode_data;
      case (state)
        IDLE: if (step) begin
          state <= RUN;
          ch    <= '0;
          busy  <= 1'b1;
        end
        RUN: begin
          if (step) overrun <= 1'b1;
          v_q[ch]   <= v_wr;
          u_q[ch]   <= u_wr;
          spike[ch] <= fire;
          if (ch == CW'(N_CH - 1)) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            ch <= ch + 1'b1;
          end
        end
        FIN: begin
          if (step) overrun <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPIKE_CNT_EN
  logic [7:0] cnt_q [N_CH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mon_cnt <= 8'd0;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= 8'd0;
    end else begin
      mon_cnt <= cnt_q[mon_ch];
      if (state == RUN && fire && cnt_q[ch] != 8'hFF) cnt_q[ch] <= cnt_q[ch] + 8'd1;
    end
  end
`else
  assign mon_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_izh_array.sv
// Self-checking bench for izh_array against an arithmetic reference model of the neuron equations.
module tb_izh_array;
  localparam int N_CH = 4;
  localparam int CW   = 2;
  localparam int FRAC = 8;
  localparam int DTS  = 1;

  logic clk = 1'b0;
  logic reset, step, cur_we, mode_we;
  logic [CW-1:0] cfg_ch, mon_ch;
  logic [7:0] cur_data, mon_v, mon_cnt;
  logic [1:0] mode_data;
  logic busy, done, overrun;
  logic [N_CH-1:0] spike;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  izh_array dut (
    .clk(clk), .reset(reset), .step(step), .cfg_ch(cfg_ch),
    .cur_we(cur_we), .cur_data(cur_data), .mode_we(mode_we), .mode_data(mode_data),
    .busy(busy), .done(done), .spike(spike), .overrun(overrun),
    .mon_ch(mon_ch), .mon_v(mon_v), .mon_cnt(mon_cnt)
  );

  // Reference model state
  longint mv [N_CH];
  longint mu [N_CH];
  int mcur [N_CH];
  int mmode [N_CH];
  int mcnt [N_CH];
  logic [N_CH-1:0] mspk;
  int a_tab [4] = '{6, 6, 6, 3};
  int c_tab [4] = '{-65, -55, -50, -65};
  int d_tab [4] = '{8, 4, 2, 2};

  function automatic longint clamp(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < N_CH; c++) begin
      mv[c] = -65 * 256; mu[c] = -13 * 256;
      mcur[c] = 0; mmode[c] = 0; mcnt[c] = 0;
    end
    mspk = '0;
  endfunction

  function automatic void model_sweep();
    longint v, u, vsq, dv, vn, bv, un;
    for (int c = 0; c < N_CH; c++) begin
      v = mv[c]; u = mu[c];
      vsq = (v * v) >>> FRAC;
      dv = (vsq >>> 5) + (vsq >>> 7) + 5 * v + 140 * 256 - u + longint'(mcur[c]) * 256;
      vn = clamp(v + (dv >>> DTS));
      bv = (v >>> 3) + (v >>> 4) + (v >>> 6);
      un = clamp(u + (((bv - u) >>> a_tab[mmode[c]]) >>> DTS));
      if (vn >= 30 * 256) begin
        mv[c] = c_tab[mmode[c]] * 256;
        mu[c] = clamp(un + d_tab[mmode[c]] * 256);
        mspk[c] = 1'b1;
        if (mcnt[c] < 255) mcnt[c]++;
      end else begin
        mv[c] = vn; mu[c] = un; mspk[c] = 1'b0;
      end
    end
  endfunction

  task automatic do_reset();
    reset = 1'b1; step = 1'b0; cur_we = 1'b0; mode_we = 1'b0;
    cfg_ch = '0; cur_data = '0; mode_data = '0; mon_ch = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic write_cur(input int c, input int val);
    @(negedge clk);
    cfg_ch = CW'(c); cur_data = 8'(val); cur_we = 1'b1;
    @(negedge clk);
    cur_we = 1'b0;
    mcur[c] = val;
  endtask

  task automatic write_mode(input int c, input int m);
    @(negedge clk);
    cfg_ch = CW'(c); mode_data = 2'(m); mode_we = 1'b1;
    @(negedge clk);
    mode_we = 1'b0;
    mmode[c] = m;
  endtask

  // One sweep; optionally writes ch0's current in the same cycle ch0 is updated.
  task automatic sweep(input bit early_wr, input int wr_val, output int nbusy, output int tdone);
    nbusy = 0; tdone = 0;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    if (early_wr) begin cfg_ch = '0; cur_data = 8'(wr_val); cur_we = 1'b1; end
    for (int i = 1; i <= 20 && tdone == 0; i++) begin
      if (i == 2) cur_we = 1'b0;
      if (busy) nbusy++;
      if (done) tdone = i;
      else @(negedge clk);
    end
    cur_we = 1'b0;
    model_sweep();
    if (early_wr) mcur[0] = wr_val;
  endtask

  task automatic check_all_v(input string name);
    logic [7:0] e;
    for (int c = 0; c < N_CH; c++) begin
      @(negedge clk); mon_ch = CW'(c);
      @(negedge clk);
      e = 8'(mv[c] >>> FRAC);
      total++;
      if (mon_v !== e) begin
        bad++;
        $display("FAIL %s mon_v ch%0d: got %h want %h", name, c, mon_v, e);
      end
    end
  endtask

  task automatic check_spike(input string name);
    total++;
    if (spike !== mspk) begin
      bad++;
      $display("FAIL %s spike: got %b want %b", name, spike, mspk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (mon_v !== 8'hBF || spike !== '0 || busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0 || mon_cnt !== 8'd0) begin
      bad++;
      $display("FAIL reset: got mon_v=%h spike=%b busy=%b done=%b ovr=%b cnt=%h want BF 0 0 0 0 00",
               mon_v, spike, busy, done, overrun, mon_cnt);
    end
    check_all_v("reset");
  endtask

  task automatic test_first_sweep();
    int nb, td;
    do_reset();
    sweep(1'b0, 0, nb, td);
    total++;
    if (nb !== N_CH || td !== N_CH + 1) begin
      bad++;
      $display("FAIL latency: got busy=%0d done_at=%0d want %0d %0d", nb, td, N_CH, N_CH + 1);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL done_width: got %b want 0", done); end
    check_spike("first");
    @(negedge clk); mon_ch = '0;
    @(negedge clk);
    total++;
    if (mon_v !== 8'hBB) begin bad++; $display("FAIL first_v0: got %h want bb", mon_v); end
    check_all_v("first");
  endtask

  task automatic test_spike();
    int nb, td;
    do_reset();
    write_cur(0, 255);
    sweep(1'b0, 0, nb, td);
    total++;
    if (spike[0] !== 1'b1) begin bad++; $display("FAIL spike0: got %b want 1", spike[0]); end
    @(negedge clk); mon_ch = '0;
    @(negedge clk);
    total++;
    if (mon_v !== 8'hBF) begin bad++; $display("FAIL spike_reset_v: got %h want bf", mon_v); end
    for (int k = 0; k < 3; k++) begin
      sweep(1'b0, 0, nb, td);
      check_spike("spike_seq");
      check_all_v("spike_seq");
    end
  endtask

  task automatic test_mode3();
    int nb, td;
    do_reset();
    write_mode(1, 3);
    write_cur(1, 255);
    sweep(1'b0, 0, nb, td);
    total++;
    if (spike[1] !== 1'b1) begin bad++; $display("FAIL mode3_spike: got %b want 1", spike[1]); end
    for (int k = 0; k < 4; k++) begin
      sweep(1'b0, 0, nb, td);
      check_spike("mode3");
      check_all_v("mode3");
    end
  endtask

  task automatic test_cfg_timing();
    int nb, td;
    do_reset();
    sweep(1'b1, 200, nb, td);
    check_spike("cfg_same_cycle");
    check_all_v("cfg_same_cycle");
    sweep(1'b0, 0, nb, td);
    check_spike("cfg_next_sweep");
    check_all_v("cfg_next_sweep");
  endtask

  task automatic test_random();
    int nb, td;
    do_reset();
    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 1) == 1) write_cur($urandom_range(0, N_CH - 1), $urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) write_mode($urandom_range(0, N_CH - 1), $urandom_range(0, 3));
      sweep(1'b0, 0, nb, td);
      total++;
      if (td !== N_CH + 1) begin bad++; $display("FAIL rand_done: got %0d want %0d", td, N_CH + 1); end
      check_spike("random");
      check_all_v("random");
    end
  endtask

  task automatic test_overrun();
    int nd, nb, td;
    do_reset();
    write_cur(2, 180);
    nd = 0;
    @(negedge clk); step = 1'b1;
    repeat (3) @(negedge clk);
    step = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) nd++;
      @(negedge clk);
    end
    model_sweep();
    total++;
    if (nd !== 1 || overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_hold: got sweeps=%0d ovr=%b want 1 1", nd, overrun);
    end
    check_all_v("overrun");
    sweep(1'b0, 0, nb, td);
    total++;
    if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
    do_reset();
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_clear: got %b want 0", overrun); end
  endtask

  task automatic test_reset_mid();
    int nd, nb, td;
    do_reset();
    write_cur(0, 255);
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || spike !== '0 || done !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got busy=%b spike=%b done=%b want 0 0 0", busy, spike, done);
    end
    @(negedge clk); reset = 1'b0;
    model_reset();
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) nd++;
      @(negedge clk);
    end
    total++;
    if (nd !== 0) begin bad++; $display("FAIL reset_mid_done: got %0d want 0", nd); end
    check_all_v("reset_mid");
    sweep(1'b0, 0, nb, td);
    check_spike("after_reset_mid");
    check_all_v("after_reset_mid");
  endtask

  task automatic test_counter();
    int nb, td;
    do_reset();
    write_cur(0, 255);
`ifdef SPIKE_CNT_EN
    for (int k = 0; k < 600; k++) sweep(1'b0, 0, nb, td);
`else
    for (int k = 0; k < 3; k++) sweep(1'b0, 0, nb, td);
    for (int c = 0; c < N_CH; c++) mcnt[c] = 0;
`endif
    @(negedge clk); mon_ch = '0;
    @(negedge clk);
    total++;
    if (mon_cnt !== 8'(mcnt[0])) begin
      bad++;
      $display("FAIL mon_cnt: got %0d want %0d", mon_cnt, mcnt[0]);
    end
    check_all_v("counter");
  endtask

  initial begin
    test_reset();
    test_first_sweep();
    test_spike();
    test_mode3();
    test_cfg_timing();
    test_random();
    test_overrun();
    test_reset_mid();
    test_counter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
